// File: rtl/mac_seq_ctrl.sv
// Sequences one MAC through a LEN-element dot product: clear, feed LEN joint A/B beats, drain MAC_LAT, emit result.
// Latency: LEN + MAC_LAT + 2 cycles from start to res_valid with no stalls; A/B readies stall on the opposite valid.
// Backpressure: result held in OUT until res_ready. Optional stall_cnt port is enabled by MAC_SEQ_CTRL_PERF_EN.
module mac_seq_ctrl #(
    parameter int LEN     = 8,
    parameter int MAC_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    input  logic [7:0]  a_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [7:0]  b_data,
    input  logic        b_valid,
    output logic        b_ready,
    output logic        mac_clr,
    output logic        mac_en,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    input  logic [23:0] mac_cout,
    output logic [23:0] res_data,
    output logic        res_valid,
    input  logic        res_ready
`ifdef MAC_SEQ_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    localparam int BW = (LEN > 1) ? $clog2(LEN + 1) : 1;

    logic [2:0]    state, state_nxt;
    logic [BW-1:0] beat_cnt;
    logic [3:0]    drain_cnt;
    logic          beat_fire, last_beat, drain_done, abort_hit;

    assign busy       = (state != S_IDLE);
    assign a_ready    = (state == S_RUN) && b_valid;
    assign b_ready    = (state == S_RUN) && a_valid;
    assign beat_fire  = (state == S_RUN) && a_valid && b_valid;
    assign last_beat  = (beat_cnt == BW'(LEN - 1));
    assign abort_hit  = abort && (state != S_IDLE);
    // The first DRAIN cycle carries the final mac_en pulse, so the count starts after it.
    assign drain_done = (state == S_DRAIN) && (drain_cnt == 4'(MAC_LAT));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !abort) state_nxt = S_CLR;
            S_CLR:   state_nxt = S_RUN;
            S_RUN:   if (beat_fire && last_beat) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_done) state_nxt = S_OUT;
            S_OUT:   if (res_ready) state_nxt = start ? S_CLR : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            mac_clr <= (state_nxt == S_CLR) || abort_hit;
            mac_en  <= beat_fire && !abort_hit;
            mac_a   <= (beat_fire && !abort_hit) ? a_data : 8'd0;
            mac_b   <= (beat_fire && !abort_hit) ? b_data : 8'd0;

            if (state == S_CLR) begin
                beat_cnt  <= '0;
                drain_cnt <= '0;
            end else begin
                if (beat_fire) beat_cnt <= beat_cnt + BW'(1);
                if (state == S_DRAIN) drain_cnt <= drain_cnt + 4'd1;
            end

            if (drain_done) res_data <= mac_cout;

            if (abort_hit)
                res_valid <= 1'b0;
            else if (drain_done)
                res_valid <= 1'b1;
            else if ((state == S_OUT) && res_ready)
                res_valid <= 1'b0;
        end
    end

`ifdef MAC_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (state == S_CLR)
            stall_cnt <= '0;
        else if ((state == S_RUN) && !beat_fire && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer that drives one `mac_ip`-style multiply-accumulate unit through a complete dot product of `LEN` element pairs. It sits between two 8-bit operand streams (typically FIFOs) and a 24-bit result consumer. The block clears the MAC, feeds it exactly `LEN` accepted operand pairs, waits out the MAC pipeline latency, then presents the accumulated result on a valid/ready port. It owns `En`/`Clr` of the MAC exclusively.

## Interface
- `LEN`, 8: dot-product length, legal 1..256; 8-bit operands with 24-bit accumulation cannot overflow in this range.
- `MAC_LAT`, 2: cycles from the last `mac_en` high cycle until `mac_cout` holds the final sum, legal 1..15.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a new dot product; sampled only in IDLE, or in OUT during the result handshake cycle.
- `abort` in 1: synchronous cancel, highest priority.
- `busy` out 1: high whenever state != IDLE.
- `a_data` in 8, `a_valid` in 1, `a_ready` out 1: A operand stream.
- `b_data` in 8, `b_valid` in 1, `b_ready` out 1: B operand stream.
- `mac_clr` out 1: MAC `Clr`.
- `mac_en` out 1: MAC `En`.
- `mac_a` out 8, `mac_b` out 8: MAC `Ain`/`Bin`.
- `mac_cout` in 24: MAC `Cout`.
- `res_data` out 24, `res_valid` out 1, `res_ready` in 1: result stream.
- `stall_cnt` out 16: present only with `MAC_SEQ_CTRL_PERF_EN` defined.

## Operation
- States: IDLE, CLR, RUN, DRAIN, OUT.
- IDLE: `start` goes to CLR.
- CLR: `mac_clr` is high for exactly 1 cycle. The beat counter and drain counter clear. Next state is RUN.
- RUN: a beat is accepted when `a_valid && b_valid`.
  - `a_ready = RUN && b_valid`; `b_ready = RUN && a_valid`. Both streams are consumed jointly and never individually.
  - The accepted pair is registered into `mac_a`/`mac_b`, with `mac_en` high on the next cycle only.
  - In a cycle with no accepted beat, `mac_en` is 0 and `mac_a`/`mac_b` are 0.
  - After the `LEN`th accepted beat, next state is DRAIN. No further ready is asserted.
- DRAIN: counts `MAC_LAT` cycles, starting the cycle after the final `mac_en` pulse. At terminal count, `mac_cout` is captured into `res_data` and state goes to OUT.
- OUT: `res_valid` is high and `res_data` is held stable until `res_ready`.
  - On handshake with `start` high: go to CLR (back-to-back operation).
  - On handshake without `start`: go to IDLE.
- `start` in CLR, RUN, or DRAIN is ignored and not queued.
- `abort` in any non-IDLE state:
  - Next state IDLE.
  - 1-cycle `mac_clr` pulse.
  - `res_valid`, `mac_en`, and both readies drop the next cycle.
  - Partial sum is discarded; no result is emitted.
- `abort` in IDLE: no effect. `abort` together with `start`: abort wins and state stays IDLE.
- `busy` is high in every state except IDLE.

## Timing
- Reset: state IDLE. `busy`, `a_ready`, `b_ready`, `mac_clr`, `mac_en`, `mac_a`, `mac_b`, `res_data`, `res_valid`, and `stall_cnt` are all 0.
- Reset asserted mid-operation: immediate return to the reset state; the MAC is cleared by its own reset.
- `mac_clr`, `mac_en`, `mac_a`, `mac_b`, `res_valid`, and `res_data` are registered. Readies are combinational from state and the opposite valid.
- `start` at edge t:
  - CLR during cycle t+1.
  - First possible accept at edge t+2.
  - First `mac_en` at cycle t+3.
- With no stalls, latency from `start` to `res_valid` is `LEN + MAC_LAT + 2` cycles.
- Back-to-back: the result handshake edge with `start` high enters CLR with no IDLE bubble.

## Configuration
- `MAC_SEQ_CTRL_PERF_EN` defined:
  - `stall_cnt` exists.
  - It clears in CLR.
  - It increments by 1 each RUN cycle with no accepted beat.
  - It saturates at 0xFFFF and holds through OUT and IDLE until the next CLR.
- `MAC_SEQ_CTRL_PERF_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- `LEN`=4, `MAC_LAT`=2, A=1,2,3,4 and B=5,6,7,8 streamed with no gaps, `res_ready`=1:
  - `res_data`=70.
  - `res_valid` 8 cycles after `start`.
  - Exactly 4 `mac_en` cycles and 1 `mac_clr` cycle.
- Same data, `b_valid` low on alternate cycles and `a_valid` always high:
  - `res_data`=70.
  - `a_ready` never high while `b_valid` is low.
  - 4 `mac_en` pulses.
  - `stall_cnt`=3 when PERF is on.
- `LEN`=8, all operands 0xFF: `res_data`=520200 (0x07F008).
- `res_ready` held low 5 cycles in OUT, then `start` and `res_ready` high together:
  - `res_data` stable throughout.
  - CLR on the next cycle.
  - Second result correct.
- `abort` after 2 accepted beats:
  - IDLE next cycle, with a `mac_clr` pulse and no `res_valid`.
  - A following `start` with A=1,1,1,1 and B=2,2,2,2 gives 8.
- `start` pulsed during RUN and DRAIN:
  - Ignored.
  - Exactly one result, then `busy`=0.
